// File: rtl/pll_scan_loader.sv
// Purpose: shifts a CHAIN_LEN-bit image MSB-first into the PLL scan port, pulses configupdate, then waits for scandone.
// Latency: 2*CHAIN_LEN shift cycles + 1 update cycle + wait (>= 3 cycles); done/err are registered and coincide with busy falling.
// Backpressure: none; req is taken only in IDLE and dropped while busy. `define PLL_SCAN_LOCK_WAIT_EN also waits for locked.
module pll_scan_loader #(
  parameter int CHAIN_LEN = 144,
  parameter int TIMEOUT   = 4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req,
  input  logic [CHAIN_LEN-1:0] image,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 scanclk,
  output logic                 scanclkena,
  output logic                 scandata,
  output logic                 configupdate,
  input  logic                 scandone,
  input  logic                 locked
);

  localparam int BW = $clog2(CHAIN_LEN);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [BW-1:0] BIT_LAST  = BW'(CHAIN_LEN - 1);
  localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT - 1);

`ifdef PLL_SCAN_LOCK_WAIT_EN
  typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_UPDATE, S_WAIT_DONE, S_WAIT_LOCK} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_UPDATE, S_WAIT_DONE} state_t;
`endif

  state_t               state, state_nxt;
  logic [CHAIN_LEN-1:0] sreg, sreg_nxt;
  logic [BW-1:0]        bcnt, bcnt_nxt;
  logic [TW-1:0]        tcnt, tcnt_nxt;
  logic                 phase, phase_nxt;
  logic                 busy_d, done_d, err_d;
  logic                 scanclk_d, scanclkena_d, scandata_d, configupdate_d;
  logic [1:0]           sd_ff;
  logic                 sd_sync;

  // two-flop synchroniser for the PLL's scandone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sd_ff <= '0;
    else        sd_ff <= {sd_ff[0], scandone};
  end
  assign sd_sync = sd_ff[1];

`ifdef PLL_SCAN_LOCK_WAIT_EN
  logic [1:0] lk_ff;
  logic       lk_sync;
  // two-flop synchroniser for the PLL's locked
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lk_ff <= '0;
    else        lk_ff <= {lk_ff[0], locked};
  end
  assign lk_sync = lk_ff[1];
`else
  logic unused_locked;
  assign unused_locked = locked;
`endif

  // state, shift register and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      sreg  <= '0;
      bcnt  <= '0;
      tcnt  <= '0;
      phase <= 1'b0;
    end else begin
      state <= state_nxt;
      sreg  <= sreg_nxt;
      bcnt  <= bcnt_nxt;
      tcnt  <= tcnt_nxt;
      phase <= phase_nxt;
    end
  end

  // next-state and datapath update; counters stop at their terminal value instead of wrapping
  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    bcnt_nxt  = bcnt;
    tcnt_nxt  = tcnt;
    phase_nxt = phase;
    case (state)
      S_IDLE: begin
        if (req) begin
          state_nxt = S_SHIFT;
          sreg_nxt  = image;
          bcnt_nxt  = BIT_LAST;
          phase_nxt = 1'b0;
        end
      end
      S_SHIFT: begin
        if (!phase) begin
          phase_nxt = 1'b1;
        end else begin
          phase_nxt = 1'b0;
          sreg_nxt  = {sreg[CHAIN_LEN-2:0], 1'b0};
          if (bcnt == '0) state_nxt = S_UPDATE;
          else            bcnt_nxt  = bcnt - 1'b1;
        end
      end
      S_UPDATE: begin
        tcnt_nxt  = '0;
        state_nxt = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (sd_sync) begin
`ifdef PLL_SCAN_LOCK_WAIT_EN
          state_nxt = S_WAIT_LOCK;
          tcnt_nxt  = '0;
`else
          state_nxt = S_IDLE;
`endif
        end else if (tcnt == TCNT_LAST) begin
          state_nxt = S_IDLE;
        end else begin
          tcnt_nxt = tcnt + 1'b1;
        end
      end
`ifdef PLL_SCAN_LOCK_WAIT_EN
      S_WAIT_LOCK: begin
        if (lk_sync || tcnt == TCNT_LAST) state_nxt = S_IDLE;
        else                              tcnt_nxt  = tcnt + 1'b1;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  // outputs are decoded from the next state so every PLL-facing pin comes straight from a flop
  always_comb begin
    busy_d         = (state_nxt != S_IDLE);
    scanclkena_d   = (state_nxt == S_SHIFT);
    scanclk_d      = (state_nxt == S_SHIFT) && phase_nxt;
    scandata_d     = (state_nxt == S_SHIFT) && sreg_nxt[CHAIN_LEN-1];
    configupdate_d = (state_nxt == S_UPDATE);
    done_d         = 1'b0;
    err_d          = 1'b0;
    if (state != S_IDLE && state_nxt == S_IDLE) begin
`ifdef PLL_SCAN_LOCK_WAIT_EN
      if (state == S_WAIT_LOCK && lk_sync) done_d = 1'b1;
      else                                 err_d  = 1'b1;
`else
      // a success and a timeout in the same cycle resolve to success
      if (sd_sync) done_d = 1'b1;
      else         err_d  = 1'b1;
`endif
    end
  end

  // output registers; reset clears them asynchronously so an aborted load never reaches configupdate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      scanclk      <= 1'b0;
      scanclkena   <= 1'b0;
      scandata     <= 1'b0;
      configupdate <= 1'b0;
    end else begin
      busy         <= busy_d;
      done         <= done_d;
      err          <= err_d;
      scanclk      <= scanclk_d;
      scanclkena   <= scanclkena_d;
      scandata     <= scandata_d;
      configupdate <= configupdate_d;
    end
  end

endmodule

// File: tb/tb_pll_scan_loader.sv
// Purpose: self-checking bench for pll_scan_loader (vector table, hand sequences, random loads).
// Latency: expected cycle of done/err comes from a timing model of the scan/update/wait sequence.
// Backpressure: exercises ignored requests while busy and back-to-back requests after completion.
module tb_pll_scan_loader;

  localparam int CL       = 144;
  localparam int TO       = 4096;
  localparam int CU_CYC   = 2 * CL + 1;   // cycle (1 = first cycle after acceptance) holding configupdate
  localparam int WD_FIRST = 2 * CL + 2;   // first cycle spent waiting for scandone
  localparam int NVEC     = 7;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req;
  logic [CL-1:0] image;
  logic          scandone;
  logic          locked;
  logic          busy, done, err, scanclk, scanclkena, scandata, configupdate;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [CL-1:0] img;
    int            sd_at;    // cycle in which scandone is raised (<=0: never)
    int            lk_at;    // cycle in which locked is raised (<=0: never)
    bit            ign;      // pulse a competing req mid-shift
    bit            exp_done; // 1: done expected, 0: err expected
    int            exp_cyc;  // cycle in which done/err must be visible
  } vec_t;

  vec_t vecs[NVEC];

  pll_scan_loader #(.CHAIN_LEN(CL), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .image        (image),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .scanclk      (scanclk),
    .scanclkena   (scanclkena),
    .scandata     (scandata),
    .configupdate (configupdate),
    .scandone     (scandone),
    .locked       (locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_img(input string name, input logic [CL-1:0] act, input logic [CL-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Timing model: an input raised in cycle j is seen by the controller two synchroniser cycles later
  // and acted on one cycle after that, so the reaction is visible in cycle j+3, but never before the
  // wait state has been entered. Each wait gives up TO cycles after it is entered; an arrival in the
  // very cycle of the give-up still counts as success.
  function automatic void model(input int sd_at, input int lk_at, output bit d, output int cyc);
    int wd_to;
    int c_sd;
    wd_to = WD_FIRST + TO;
    if (sd_at <= 0) begin
      d = 1'b0; cyc = wd_to; return;
    end
    c_sd = imax(sd_at + 3, WD_FIRST + 1);
    if (c_sd > wd_to) begin
      d = 1'b0; cyc = wd_to; return;
    end
`ifdef PLL_SCAN_LOCK_WAIT_EN
    begin
      int c_l;
      int lk_to;
      lk_to = c_sd + TO;
      c_l   = (lk_at <= 0) ? lk_to + 1 : imax(lk_at + 3, c_sd + 1);
      if (c_l > lk_to) begin d = 1'b0; cyc = lk_to; end
      else             begin d = 1'b1; cyc = c_l;   end
    end
`else
    d = 1'b1; cyc = c_sd;
    if (lk_at < -1) d = 1'b1;
`endif
  endfunction

  // Called at a negedge; starts one load and follows it to done/err, checking the scan waveform.
  task automatic run_op(input int idx, input logic [CL-1:0] img, input int sd_at, input int lk_at,
                        input bit ign, input bit exp_done, input int exp_cyc);
    logic [CL-1:0] got;
    int   k, nr, ncu, cu_at, busy_low, end_k;
    logic prev, fin, got_done, got_err, end_busy;
    string p;
    p = $sformatf("op%0d", idx);
    got = '0; nr = 0; ncu = 0; cu_at = -1; busy_low = 0; end_k = -1;
    prev = 1'b0; fin = 1'b0; got_done = 1'b0; got_err = 1'b0; end_busy = 1'b1;
    scandone = 1'b0; locked = 1'b0;
    req = 1'b1; image = img;
    @(negedge clk);
    k = 1;
    req = 1'b0;
    chk({p, " first_busy"}, int'(busy), 1);
    chk({p, " first_sclk"}, int'(scanclk), 0);
    chk({p, " first_ena"}, int'(scanclkena), 1);
    chk({p, " first_data"}, int'(scandata), int'(img[CL-1]));
    chk({p, " first_flags"}, int'({done, err, configupdate}), 0);
    while (!fin && k <= exp_cyc + 10) begin
      if (scanclk && !prev) begin
        got = {got[CL-2:0], scandata};
        nr++;
      end
      prev = scanclk;
      if (configupdate) begin ncu++; cu_at = k; end
      if (done || err) begin
        fin = 1'b1; end_k = k; got_done = done; got_err = err; end_busy = busy;
      end else begin
        if (!busy) busy_low++;
        scandone = (sd_at > 0 && k >= sd_at);
        locked   = (lk_at > 0 && k >= lk_at);
        if (ign && (k == 40 || k == 41)) begin req = 1'b1; image = ~img; end
        else begin req = 1'b0; image = img; end
        @(negedge clk);
        k++;
      end
    end
    chk({p, " end_seen"}, int'(fin), 1);
    chk({p, " rise_count"}, nr, CL);
    chk_img({p, " bits"}, got, img);
    chk({p, " cu_count"}, ncu, 1);
    chk({p, " cu_cycle"}, cu_at, CU_CYC);
    chk({p, " end_cycle"}, end_k, exp_cyc);
    chk({p, " done"}, int'(got_done), int'(exp_done));
    chk({p, " err"}, int'(got_err), int'(!exp_done));
    chk({p, " busy_at_end"}, int'(end_busy), 0);
    chk({p, " busy_gap"}, busy_low, 0);
  endtask

  initial begin
    logic [CL-1:0] rimg;
    int   k, nr, sd, lk;
    logic prev;
    bit   ed;
    int   ec;

    rst_n = 1'b0; req = 1'b0; image = '0; scandone = 1'b0; locked = 1'b0;

    vecs[0] = '{img: {1'b1, 142'b0, 1'b1}, sd_at: CU_CYC + 20, lk_at: CU_CYC + 70, ign: 1'b0, exp_done: 1'b0, exp_cyc: 0};
    vecs[1] = '{img: {36{4'hA}},   sd_at: -1,               lk_at: -1, ign: 1'b0, exp_done: 1'b0, exp_cyc: 0};
    vecs[2] = '{img: {CL{1'b1}},   sd_at: 1,                lk_at: 1,  ign: 1'b1, exp_done: 1'b0, exp_cyc: 0};
    vecs[3] = '{img: {36{4'h5}},   sd_at: WD_FIRST + TO - 3, lk_at: 1, ign: 1'b0, exp_done: 1'b0, exp_cyc: 0};
    vecs[4] = '{img: {18{8'h3C}},  sd_at: WD_FIRST + TO - 2, lk_at: 1, ign: 1'b0, exp_done: 1'b0, exp_cyc: 0};
    vecs[5] = '{img: {9{16'h0F0F}}, sd_at: CU_CYC + 20,     lk_at: -1, ign: 1'b0, exp_done: 1'b0, exp_cyc: 0};
    vecs[6] = '{img: '0,           sd_at: CU_CYC + 5,       lk_at: CU_CYC + 5, ign: 1'b0, exp_done: 1'b0, exp_cyc: 0};
    for (int i = 0; i < NVEC; i++) begin
      model(vecs[i].sd_at, vecs[i].lk_at, ed, ec);
      vecs[i].exp_done = ed;
      vecs[i].exp_cyc  = ec;
    end

    // reset state
    @(negedge clk); @(negedge clk);
    chk("reset_outputs", int'({busy, done, err, scanclk, scanclkena, scandata, configupdate}), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", int'({busy, done, err, scanclk, scanclkena, scandata, configupdate}), 0);

    // vector table, back to back
    for (int i = 0; i < NVEC; i++)
      run_op(i, vecs[i].img, vecs[i].sd_at, vecs[i].lk_at, vecs[i].ign, vecs[i].exp_done, vecs[i].exp_cyc);

    // mid-shift reset around bit 70
    @(negedge clk);
    scandone = 1'b0; locked = 1'b0; req = 1'b1; image = {36{4'hC}};
    @(negedge clk);
    req = 1'b0; nr = 0; prev = 1'b0; k = 0;
    while (nr < 70 && k < 400) begin
      if (scanclk && !prev) nr++;
      prev = scanclk;
      @(negedge clk);
      k++;
    end
    chk("mid_reached_bit70", int'(nr >= 70), 1);
    #2 rst_n = 1'b0;
    #1 chk("mid_reset_outputs", int'({busy, done, err, scanclk, scanclkena, scandata, configupdate}), 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("mid_reset_hold%0d", c), int'({busy, done, err, configupdate}), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    model(CU_CYC + 20, CU_CYC + 30, ed, ec);
    run_op(100, {36{4'hC}}, CU_CYC + 20, CU_CYC + 30, 1'b0, ed, ec);

    // random loads
    for (int r = 0; r < 6; r++) begin
      rimg = {$urandom(), $urandom(), $urandom(), $urandom(), 16'($urandom())};
      sd = $urandom_range(1, 2 * CL + 60);
      lk = sd + $urandom_range(0, 80);
      model(sd, lk, ed, ec);
      run_op(200 + r, rimg, sd, lk, ($urandom_range(0, 1) == 1), ed, ec);
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
